muldiv_unit: RTL and testbench

Parametrised, multi-cycle multiply/divide execution unit. It implements the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for a configurable data width. It sits beside the single-cycle ALU in the execute stage and uses a valid/ready request/response handshake, so the pipeline can stall on it. Operands and result are registered, and a tag is carried through unchanged for writeback steering.

---
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M-style multiply/divide unit with valid/ready handshake.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// followed by a single sign-correction cycle. Divide-by-zero and signed
// overflow bypass the iteration and complete directly.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  operand1_i,
  input  logic [XLEN-1:0]  operand2_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] MOST_NEG = XLEN'(1) << (XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic [TAG_W-1:0]    tag_q;
  logic                neg_q;
  logic [XLEN-1:0]     opnd_q;   // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0]     rem_q;    // partial remainder
  logic [2*XLEN-1:0]   acc;      // {product hi, multiplier} or {0, quotient}
  logic [CNT_W-1:0]    cnt;

  logic                rs1_signed, rs2_signed, s1, s2, neg_req;
  logic [XLEN-1:0]     mag1, mag2;
  logic                div_zero, div_ovf;
  logic [XLEN-1:0]     fast_res;

  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       div_diff;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;

  assign req_ready_o = (state == IDLE) && !flush_i;
  assign busy_o      = (state != IDLE);

  // Request decode: signedness, magnitudes and fast-path detection
  always_comb begin
    rs1_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                 (op_i == OP_DIV)  || (op_i == OP_REM);
    rs2_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    s1         = rs1_signed && operand1_i[XLEN-1];
    s2         = rs2_signed && operand2_i[XLEN-1];
    mag1       = s1 ? (XLEN'(0) - operand1_i) : operand1_i;
    mag2       = s2 ? (XLEN'(0) - operand2_i) : operand2_i;
    neg_req    = (op_i == OP_REM) ? s1 : (s1 ^ s2);
    div_zero   = op_i[2] && (operand2_i == '0);
    div_ovf    = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                 (operand1_i == MOST_NEG) && (operand2_i == '1);
    fast_res   = '0;
    if (div_zero) begin
      fast_res = op_i[1] ? operand1_i : '1;
    end else if (div_ovf) begin
      fast_res = op_i[1] ? '0 : operand1_i;
    end
  end

  // Iteration step and sign-correction datapath
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {rem_q, acc[XLEN-1]};
    div_diff = rem_sh - {1'b0, opnd_q};
    prod     = neg_q ? ((2*XLEN)'(0) - acc) : acc;
    quo_fix  = neg_q ? (XLEN'(0) - acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem_fix  = neg_q ? (XLEN'(0) - rem_q) : rem_q;
    case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo_fix;
      OP_REM, OP_REMU:              fix_res = rem_fix;
      default:                      fix_res = '0;
    endcase
  end

  // Control FSM with registered datapath and outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      op_q           <= '0;
      tag_q          <= '0;
      neg_q          <= 1'b0;
      opnd_q         <= '0;
      rem_q          <= '0;
      acc            <= '0;
      cnt            <= '0;
      result_valid_o <= 1'b0;
      result_o       <= '0;
      tag_o          <= '0;
    end else if (flush_i) begin
      state          <= IDLE;
      cnt            <= '0;
      result_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            op_q  <= op_i;
            tag_q <= tag_i;
            cnt   <= '0;
            if (div_zero || div_ovf) begin
              result_o       <= fast_res;
              tag_o          <= tag_i;
              result_valid_o <= 1'b1;
              state          <= DONE;
            end else begin
              neg_q <= neg_req;
              rem_q <= '0;
              if (op_i[2]) begin
                opnd_q <= mag2;
                acc    <= {{XLEN{1'b0}}, mag1};
              end else begin
                opnd_q <= mag1;
                acc    <= {{XLEN{1'b0}}, mag2};
              end
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (op_q[2]) begin
            acc[XLEN-1:0] <= {acc[XLEN-2:0], ~div_diff[XLEN]};
            rem_q         <= div_diff[XLEN] ? rem_sh[XLEN-1:0] : div_diff[XLEN-1:0];
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          result_o       <= fix_res;
          tag_o          <= tag_q;
          result_valid_o <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            cnt            <= '0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32 and XLEN=16 instances).
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [31:0] op1, op2;
  logic [4:0]  tag;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic [4:0]  tag_out;
  logic        busy;

  logic        flush16;
  logic        req_valid16;
  logic        req_ready16;
  logic [2:0]  op16;
  logic [15:0] a16, b16;
  logic [2:0]  tag16;
  logic        result_valid16;
  logic        result_ready16;
  logic [15:0] result16;
  logic [2:0]  tag_out16;
  logic        busy16;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .operand1_i(op1), .operand2_i(op2), .tag_i(tag),
    .result_valid_o(result_valid), .result_ready_i(result_ready),
    .result_o(result), .tag_o(tag_out), .busy_o(busy)
  );

  muldiv_unit #(.XLEN(16), .TAG_W(3)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush16),
    .req_valid_i(req_valid16), .req_ready_o(req_ready16),
    .op_i(op16), .operand1_i(a16), .operand2_i(b16), .tag_i(tag16),
    .result_valid_o(result_valid16), .result_ready_i(result_ready16),
    .result_o(result16), .tag_o(tag_out16), .busy_o(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RV32M semantics for width w using 64-bit integer arithmetic
  function automatic logic [63:0] ref_model(input int w, input logic [2:0] o,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, minv, p;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    minv = 64'd1 << (w - 1);
    sa   = longint'(a << (64 - w)) >>> (64 - w);
    sb   = longint'(b << (64 - w)) >>> (64 - w);
    case (o)
      3'd0: begin p = a * b; return p & mask; end
      3'd1: begin p = sa * sb; return (p >> w) & mask; end
      3'd2: begin p = sa * longint'(b); return (p >> w) & mask; end
      3'd3: begin p = a * b; return (p >> w) & mask; end
      3'd4: begin
        if (b == 0) return mask;
        if (a == minv && b == mask) return a;
        p = sa / sb; return p & mask;
      end
      3'd5: return (b == 0) ? mask : (a / b);
      3'd6: begin
        if (b == 0) return a;
        if (a == minv && b == mask) return 64'd0;
        p = sa % sb; return p & mask;
      end
      default: return (b == 0) ? a : (a % b);
    endcase
  endfunction

  function automatic int ref_latency(input int w, input logic [2:0] o,
                                     input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, minv;
    mask = (64'd1 << w) - 64'd1;
    minv = 64'd1 << (w - 1);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == minv && b == mask) return 1;
    return w + 2;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request on the 32-bit unit and wait for its result (ready held high)
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, output logic [31:0] r, output logic [4:0] rt,
                       output int lat);
    @(negedge clk);
    op = o; op1 = a; op2 = b; tag = t; req_valid = 1'b1; result_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; op1 = $urandom; op2 = $urandom; tag = 5'($urandom);
    lat = -1; r = '0; rt = '0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        r = result; rt = tag_out; lat = n;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_op16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] t, output logic [15:0] r, output logic [2:0] rt,
                         output int lat);
    @(negedge clk);
    op16 = o; a16 = a; b16 = b; tag16 = t; req_valid16 = 1'b1; result_ready16 = 1'b1;
    @(posedge clk);
    #1;
    req_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = -1; r = '0; rt = '0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (result_valid16 === 1'b1) begin
        r = result16; rt = tag_out16; lat = n;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++; if (tag_out !== 5'h0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", tag_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_checks++; if (result_valid16 !== 1'b0) begin n_fail++; $display("FAIL reset_valid16: got %b want 0", result_valid16); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul_directed();
    logic [2:0]  ops [4] = '{3'd0, 3'd3, 3'd1, 3'd2};
    logic [31:0] as  [4] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2};
    logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF};
    logic [31:0] r; logic [4:0] rt; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], 5'(i + 1), r, rt, lat);
      n_checks++; if (r !== exp[i]) begin n_fail++; $display("FAIL mul_dir_result[%0d]: got %h want %h", i, r, exp[i]); end
      n_checks++; if (rt !== 5'(i + 1)) begin n_fail++; $display("FAIL mul_dir_tag[%0d]: got %0d want %0d", i, rt, i + 1); end
      n_checks++; if (lat != 34) begin n_fail++; $display("FAIL mul_dir_latency[%0d]: got %0d want 34", i, lat); end
    end
  endtask

  task automatic test_div_directed();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] r; logic [4:0] rt; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], 5'(i + 10), r, rt, lat);
      n_checks++; if (r !== exp[i]) begin n_fail++; $display("FAIL div_dir_result[%0d]: got %h want %h", i, r, exp[i]); end
      n_checks++; if (rt !== 5'(i + 10)) begin n_fail++; $display("FAIL div_dir_tag[%0d]: got %0d want %0d", i, rt, i + 10); end
      n_checks++; if (lat != 34) begin n_fail++; $display("FAIL div_dir_latency[%0d]: got %0d want 34", i, lat); end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};
    logic [31:0] r; logic [4:0] rt; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], 5'(i + 20), r, rt, lat);
      n_checks++; if (r !== exp[i]) begin n_fail++; $display("FAIL fast_result[%0d]: got %h want %h", i, r, exp[i]); end
      n_checks++; if (rt !== 5'(i + 20)) begin n_fail++; $display("FAIL fast_tag[%0d]: got %0d want %0d", i, rt, i + 20); end
      n_checks++; if (lat != 1) begin n_fail++; $display("FAIL fast_latency[%0d]: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [2:0] o; logic [31:0] a, b, r, exp; logic [4:0] t, rt; int lat, el;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      t = 5'($urandom);
      exp = 32'(ref_model(32, o, 64'(a), 64'(b)));
      el  = ref_latency(32, o, 64'(a), 64'(b));
      do_op(o, a, b, t, r, rt, lat);
      n_checks++; if (r !== exp) begin n_fail++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, o, a, b, r, exp); end
      n_checks++; if (rt !== t) begin n_fail++; $display("FAIL rand_tag[%0d]: got %0d want %0d", i, rt, t); end
      n_checks++; if (lat != el) begin n_fail++; $display("FAIL rand_latency[%0d] op=%0d: got %0d want %0d", i, o, lat, el); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic [4:0] rt; int lat; int seen;
    @(negedge clk);
    op = 3'd5; op1 = 32'd1000; op2 = 32'd9; tag = 5'h15; req_valid = 1'b1; result_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin seen = n; break; end
    end
    n_checks++; if (seen != 34) begin n_fail++; $display("FAIL bp_latency: got %0d want 34", seen); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (result !== 32'd111 || tag_out !== 5'h15 || req_ready !== 1'b0 || result_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got res=%h tag=%h ready=%b valid=%b want res=0000006f tag=15 ready=0 valid=1",
                 k, result, tag_out, req_ready, result_valid);
      end
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b want 1", req_ready); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after: got %b want 0", result_valid); end
    do_op(3'd7, 32'd1000, 32'd9, 5'h03, r, rt, lat);
    n_checks++; if (r !== 32'd1 || rt !== 5'h03) begin n_fail++; $display("FAIL b2b_first: got %h/%h want 00000001/03", r, rt); end
    do_op(3'd0, 32'd12, 32'd11, 5'h1C, r, rt, lat);
    n_checks++; if (r !== 32'd132 || rt !== 5'h1C) begin n_fail++; $display("FAIL b2b_second: got %h/%h want 00000084/1c", r, rt); end
  endtask

  task automatic test_flush();
    logic [31:0] r; logic [4:0] rt; int lat; int valid_seen; int busy_seen;
    @(negedge clk);
    op = 3'd0; op1 = 32'd123; op2 = 32'd456; tag = 5'd7; req_valid = 1'b1; result_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1; op = 3'd3; tag = 5'd9; req_valid = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_calc: got %b want 0", req_ready); end
    @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
    flush = 1'b0; req_valid = 1'b0;
    valid_seen = 0; busy_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (result_valid === 1'b1) valid_seen++;
      if (busy === 1'b1) busy_seen++;
    end
    n_checks++; if (valid_seen != 0 || busy_seen != 0) begin n_fail++; $display("FAIL flush_no_result: got valid=%0d busy=%0d cycles want 0/0", valid_seen, busy_seen); end
    // Request offered together with flush while idle must be ignored
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; op = 3'd0; op1 = 32'd5; op2 = 32'd5; tag = 5'd2;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_idle: got %b want 0", req_ready); end
    @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_accept_idle: got busy=%b want 0", busy); end
    flush = 1'b0; req_valid = 1'b0;
    do_op(3'd0, 32'd123, 32'd456, 5'd7, r, rt, lat);
    n_checks++; if (r !== 32'd56088 || rt !== 5'd7 || lat != 34) begin n_fail++; $display("FAIL flush_recover: got %h/%0d lat %0d want 0000db18/7 lat 34", r, rt, lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic [4:0] rt; int lat;
    @(negedge clk);
    op = 3'd0; op1 = 32'hDEAD; op2 = 32'hBEEF; tag = 5'd11; req_valid = 1'b1; result_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (result_valid !== 1'b0 || result !== 32'h0 || tag_out !== 5'h0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%b res=%h tag=%h busy=%b ready=%b want 0/0/0/0/1",
               result_valid, result, tag_out, busy, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd0, 32'd3, 32'd5, 5'd13, r, rt, lat);
    n_checks++; if (r !== 32'd15 || rt !== 5'd13 || lat != 34) begin n_fail++; $display("FAIL reset_recover: got %h/%0d lat %0d want 0000000f/13 lat 34", r, rt, lat); end
  endtask

  task automatic test_xlen16();
    logic [2:0]  ops [4] = '{3'd0, 3'd3, 3'd1, 3'd2};
    logic [15:0] as  [4] = '{16'd7, 16'hFFFF, 16'h8000, 16'hFFFF};
    logic [15:0] bs  [4] = '{16'hFFFD, 16'hFFFF, 16'h8000, 16'd2};
    logic [15:0] exp [4] = '{16'hFFEB, 16'hFFFE, 16'h4000, 16'hFFFF};
    logic [15:0] r, a, b, e; logic [2:0] rt, t, o; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op16(ops[i], as[i], bs[i], 3'(i + 4), r, rt, lat);
      n_checks++; if (r !== exp[i]) begin n_fail++; $display("FAIL x16_result[%0d]: got %h want %h", i, r, exp[i]); end
      n_checks++; if (rt !== 3'(i + 4)) begin n_fail++; $display("FAIL x16_tag[%0d]: got %0d want %0d", i, rt, 3'(i + 4)); end
      n_checks++; if (lat != 18) begin n_fail++; $display("FAIL x16_latency[%0d]: got %0d want 18", i, lat); end
    end
    for (int i = 0; i < 20; i++) begin
      o = 3'($urandom_range(0, 7));
      a = (i % 5 == 0) ? 16'h8000 : 16'($urandom);
      b = (i % 7 == 0) ? 16'h0 : ((i % 5 == 0) ? 16'hFFFF : 16'($urandom));
      t = 3'($urandom);
      e = 16'(ref_model(16, o, 64'(a), 64'(b)));
      do_op16(o, a, b, t, r, rt, lat);
      n_checks++;
      if (r !== e || rt !== t || lat != ref_latency(16, o, 64'(a), 64'(b))) begin
        n_fail++;
        $display("FAIL x16_rand[%0d] op=%0d a=%h b=%h: got %h/%0d lat %0d want %h/%0d lat %0d",
                 i, o, a, b, r, rt, lat, e, t, ref_latency(16, o, 64'(a), 64'(b)));
      end
    end
  endtask

  initial begin
    flush = 1'b0; req_valid = 1'b0; op = '0; op1 = '0; op2 = '0; tag = '0; result_ready = 1'b1;
    flush16 = 1'b0; req_valid16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; tag16 = '0; result_ready16 = 1'b1;
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_fast_path();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_xlen16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
